// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state type, register offsets and STATUS bit positions
package uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam int ST_BUSY  = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_EMPTY = 2;
  localparam int ST_OVF   = 3;
endpackage

// File: rtl/uart_tx_periph_fifo.sv
// sync_fifo: circular-buffer FIFO; a push while full is accepted only alongside a pop
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     ph1,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic do_push, do_pop;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign do_push = push & (~full | pop);
  assign do_pop = pop & ~empty;
  assign dout = mem[rptr];
  always_ff @(posedge ph1 or negedge reset) begin
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop) rptr <= rptr + 1'b1;
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end
  always_ff @(posedge ph1) begin
    if (do_push) mem[wptr] <= din;
  end
endmodule

// File: rtl/uart_tx_periph.sv
// uart_tx_periph: memory-mapped 8N1 transmitter with a byte FIFO and CPU-visible registers
module uart_tx_periph
  import uart_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'hD000,
  parameter int          DEPTH     = 4,
  parameter int          BAUD_DIV  = 16
) (
  input  logic        ph1,
  input  logic        reset,
  input  logic [15:0] address,
  input  logic [7:0]  data_in,
  input  logic        read_en,
  output logic [7:0]  data_out,
  output logic        data_oe,
  output logic        tx,
  output logic        irq
);
  localparam int CW = $clog2(BAUD_DIV);
  tx_state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] bit_idx, bit_n;
  logic [7:0] shift, shift_n, last_data, fifo_dout, status;
  logic [$clog2(DEPTH):0] fifo_count;
  logic tx_n, pop, full, empty, has_data, start_ok, baud_done;
  logic tx_en, irq_en, overflow;
  logic sel, wr, wr_data, wr_status, wr_ctrl;
  logic [1:0] off;
  assign sel = address[15:2] == BASE_ADDR[15:2];
  assign off = address[1:0];
  assign wr = sel & ~read_en;
  assign wr_data = wr & (off == REG_DATA);
  assign wr_status = wr & (off == REG_STATUS);
  assign wr_ctrl = wr & (off == REG_CTRL);
  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_fifo (
    .ph1  (ph1),
    .reset(reset),
    .push (wr_data),
    .pop  (pop),
    .din  (data_in),
    .dout (fifo_dout),
    .full (full),
    .empty(empty),
    .count(fifo_count)
  );
  assign has_data = fifo_count != '0;
  assign start_ok = tx_en & has_data;
  assign baud_done = cnt == CW'(BAUD_DIV - 1);
  always_comb begin
    status = 8'h00;
    status[ST_BUSY] = state != IDLE;
    status[ST_FULL] = full;
    status[ST_EMPTY] = empty;
    status[ST_OVF] = overflow;
  end
  assign data_oe = sel & read_en;
  assign data_out = ~sel ? 8'h00 :
                    off == REG_DATA   ? last_data :
                    off == REG_STATUS ? status :
                    off == REG_CTRL   ? {6'b0, irq_en, tx_en} : 8'h00;
  assign irq = empty & irq_en;
  always_ff @(posedge ph1 or negedge reset) begin
    if (!reset) begin
      last_data <= 8'h00;
      tx_en <= 1'b1;
      irq_en <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (wr_data) last_data <= data_in;
      if (wr_ctrl) {irq_en, tx_en} <= data_in[1:0];
      if (wr_data & full & ~pop) overflow <= 1'b1;
      else if (wr_status & data_in[ST_OVF]) overflow <= 1'b0;
    end
  end
  always_ff @(posedge ph1 or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      bit_idx <= '0;
      shift <= '0;
      tx <= 1'b1;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      bit_idx <= bit_n;
      shift <= shift_n;
      tx <= tx_n;
    end
  end
  // tx_n is the line level for the state being entered, so tx stays registered
  always_comb begin
    state_n = state;
    cnt_n = cnt + 1'b1;
    bit_n = bit_idx;
    shift_n = shift;
    tx_n = tx;
    pop = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_n = '0;
        tx_n = ~start_ok;
        pop = start_ok;
        shift_n = start_ok ? fifo_dout : shift;
        state_n = start_ok ? START : IDLE;
      end
      START: if (baud_done) begin
        cnt_n = '0;
        bit_n = '0;
        tx_n = shift[0];
        state_n = DATA;
      end
      DATA: if (baud_done) begin
        cnt_n = '0;
        shift_n = shift >> 1;
        bit_n = bit_idx + 3'd1;
        tx_n = bit_idx == 3'd7 ? 1'b1 : shift[1];
        state_n = bit_idx == 3'd7 ? STOP : DATA;
      end
      STOP: if (baud_done) begin
        cnt_n = '0;
        pop = start_ok;
        shift_n = start_ok ? fifo_dout : shift;
        tx_n = ~start_ok;
        state_n = start_ok ? START : IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_uart_tx_periph.sv
// tb_uart_tx_periph: register table, directed frame timing and random bursts checked by a line decoder
module tb_uart_tx_periph;
  localparam logic [15:0] BASE = 16'hD000;
  localparam int B = 4;
  localparam int D = 4;
  localparam logic [15:0] A_DATA = BASE, A_STAT = BASE + 16'd1, A_CTRL = BASE + 16'd2;
  typedef struct {
    logic [15:0] addr;
    logic        rd;
    logic [7:0]  dout;
    logic        oe;
  } rd_vec_t;
  logic ph1 = 1'b0, reset = 1'b0, read_en = 1'b1;
  logic [15:0] address = 16'h0000;
  logic [7:0] data_in = 8'h00, data_out;
  logic data_oe, tx, irq;
  int n_tests = 0, n_fail = 0, mon_errs = 0;
  bit mon_en = 1'b1;
  logic [9:0] mon_bits;
  logic [7:0] rxq[$], expq[$];

  uart_tx_periph #(.BASE_ADDR(BASE), .DEPTH(D), .BAUD_DIV(B)) dut (
    .ph1(ph1), .reset(reset), .address(address), .data_in(data_in), .read_en(read_en),
    .data_out(data_out), .data_oe(data_oe), .tx(tx), .irq(irq)
  );

  always #5 ph1 = ~ph1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    address = a; data_in = d; read_en = 1'b0;
    @(negedge ph1);
    address = 16'h0000; data_in = 8'h00; read_en = 1'b1;
  endtask

  task automatic rd(input logic [15:0] a, output logic [7:0] d);
    address = a; read_en = 1'b1;
    #1;
    d = data_out;
    address = 16'h0000;
  endtask

  function automatic logic fbit(input logic [7:0] b, input int k);
    return k == 0 ? 1'b0 : k == 9 ? 1'b1 : b[k-1];
  endfunction

  task automatic wait_idle();
    logic [7:0] s;
    int t = 0;
    rd(A_STAT, s);
    while (s !== 8'h04 && t < 1000) begin
      @(negedge ph1);
      rd(A_STAT, s);
      t++;
    end
    check("idle_reached", s, 8'h04);
  endtask

  task automatic drain(input string name);
    int t = 0;
    while (rxq.size() < expq.size() && t < 2000) begin
      @(negedge ph1);
      t++;
    end
    check({name, "_rx_count"}, rxq.size(), expq.size());
    while (expq.size() > 0 && rxq.size() > 0) check({name, "_rx_byte"}, rxq.pop_front(), expq.pop_front());
    rxq.delete();
    expq.delete();
  endtask

  // Line decoder: every cycle of each bit must hold the same level
  initial begin
    forever begin
      @(negedge ph1);
      if (mon_en && reset && tx === 1'b0) begin
        for (int k = 0; k < 10; k++) begin
          for (int c = 0; c < B; c++) begin
            if (k != 0 || c != 0) @(negedge ph1);
            if (c == 0) mon_bits[k] = tx;
            else if (tx !== mon_bits[k]) mon_errs++;
          end
        end
        if (mon_bits[0] !== 1'b0 || mon_bits[9] !== 1'b1) mon_errs++;
        rxq.push_back(mon_bits[8:1]);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    rd_vec_t tv[7];
    logic [7:0] r, b, last;
    int n;
    tv[0] = '{16'hD000, 1'b1, 8'h00, 1'b1};
    tv[1] = '{16'hD001, 1'b1, 8'h04, 1'b1};
    tv[2] = '{16'hD002, 1'b1, 8'h01, 1'b1};
    tv[3] = '{16'hD003, 1'b1, 8'h00, 1'b1};
    tv[4] = '{16'hD004, 1'b1, 8'h00, 1'b0};
    tv[5] = '{16'hC001, 1'b1, 8'h00, 1'b0};
    tv[6] = '{16'hC002, 1'b0, 8'h00, 1'b0};
    repeat (3) @(negedge ph1);
    check("tx_in_reset", tx, 1'b1);
    reset = 1'b1;
    @(negedge ph1);
    for (int i = 0; i < 7; i++) begin
      address = tv[i].addr; read_en = tv[i].rd;
      #1;
      check($sformatf("tbl%0d_dout", i), data_out, tv[i].dout);
      check($sformatf("tbl%0d_oe", i), data_oe, tv[i].oe);
      address = 16'h0000; read_en = 1'b1;
      @(negedge ph1);
    end
    check("reset_tx", tx, 1'b1);
    check("reset_irq", irq, 1'b0);

    wr(A_DATA, 8'hA5);
    expq.push_back(8'hA5);
    check("a5_pre_tx", tx, 1'b1);
    rd(A_STAT, r);
    check("a5_pre_status", r, 8'h00);
    for (int i = 0; i < 40; i++) begin
      @(negedge ph1);
      check($sformatf("a5_tx_c%0d", i), tx, fbit(8'hA5, i / B));
      rd(A_STAT, r);
      check("a5_busy_status", r, 8'h05);
    end
    @(negedge ph1);
    rd(A_STAT, r);
    check("a5_post_status", r, 8'h04);
    rd(A_DATA, r);
    check("a5_data_readback", r, 8'hA5);
    drain("a5");

    wr(A_CTRL, 8'h00);
    for (int i = 1; i <= 5; i++) wr(A_DATA, 8'(i));
    rd(A_STAT, r);
    check("ovf_status", r, 8'h0A);
    rd(A_DATA, r);
    check("ovf_last_data", r, 8'h05);
    repeat (20) @(negedge ph1);
    check("txen0_idle_tx", tx, 1'b1);
    wr(A_STAT, 8'h08);
    rd(A_STAT, r);
    check("ovf_cleared", r, 8'h02);

    for (int i = 1; i <= 4; i++) expq.push_back(8'(i));
    wr(A_CTRL, 8'h01);
    check("b2b_pre_tx", tx, 1'b1);
    for (int i = 0; i < 160; i++) begin
      @(negedge ph1);
      check($sformatf("b2b_tx_c%0d", i), tx, fbit(8'(i / 40 + 1), (i % 40) / B));
      rd(A_STAT, r);
      check("b2b_empty", r[2], 1'(i >= 120));
    end
    @(negedge ph1);
    rd(A_STAT, r);
    check("b2b_post_status", r, 8'h04);
    drain("b2b");

    for (int i = 0; i < 5; i++) begin
      wr(A_DATA, 8'h11 + 8'(i));
      expq.push_back(8'h11 + 8'(i));
    end
    repeat (36) @(negedge ph1);
    rd(A_STAT, r);
    check("pp_full_before", r, 8'h03);
    wr(A_DATA, 8'h16);
    expq.push_back(8'h16);
    rd(A_STAT, r);
    check("pp_full_after", r, 8'h03);
    wait_idle();
    drain("pushpop");

    for (int k = 0; k < 12; k++) begin
      n = $urandom_range(1, 4);
      last = 8'h00;
      for (int j = 0; j < n; j++) begin
        b = 8'($urandom);
        wr(A_DATA, b);
        expq.push_back(b);
        last = b;
        repeat ($urandom_range(0, 3)) @(negedge ph1);
      end
      rd(A_DATA, r);
      check("rand_last_data", r, last);
      wait_idle();
      drain("rand");
    end

    mon_en = 1'b0;
    wr(A_DATA, 8'h3C);
    repeat (10) @(negedge ph1);
    check("mid_frame_tx_low_before_reset", tx, 1'b0);
    #2 reset = 1'b0;
    #1;
    check("async_reset_tx", tx, 1'b1);
    rd(A_STAT, r);
    check("async_reset_status", r, 8'h04);
    check("async_reset_irq", irq, 1'b0);
    @(negedge ph1);
    reset = 1'b1;
    @(negedge ph1);
    rd(A_CTRL, r);
    check("post_reset_ctrl", r, 8'h01);
    rd(A_DATA, r);
    check("post_reset_data", r, 8'h00);
    check("post_reset_irq", irq, 1'b0);
    wr(A_CTRL, 8'h03);
    check("irq_on_empty", irq, 1'b1);
    rd(A_CTRL, r);
    check("ctrl_03", r, 8'h03);
    repeat (30) @(negedge ph1);
    check("post_reset_idle_tx", tx, 1'b1);
    check("monitor_frame_errors", mon_errs, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
